// File: rtl/sopc_bus_decoder.sv
// sopc_bus_decoder
//   Single-master to NSLV-slave bus decoder. A master request is registered,
//   its slave index is decoded from addr[SEL_LSB +: SELW], and the request is
//   presented to exactly one slave until that slave acks. Out-of-range indices
//   complete with a one-cycle m_err pulse.
//   Optional feature: define BUS_TIMEOUT_EN to bound the WAIT state to
//   TIMEOUT cycles; the transaction then ends with m_err.
module sopc_bus_decoder #(
   parameter int unsigned NSLV    = 4,
   parameter int unsigned SEL_LSB = 28,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               m_ce,
   input  logic               m_we,
   input  logic [31:0]        m_addr,
   input  logic [31:0]        m_wdata,
   input  logic [3:0]         m_sel,
   output logic [31:0]        m_rdata,
   output logic               m_ack,
   output logic               m_err,
   output logic [NSLV-1:0]    s_ce,
   output logic               s_we,
   output logic [31:0]        s_addr,
   output logic [3:0]         s_sel,
   output logic [31:0]        s_wdata,
   input  logic [NSLV*32-1:0] s_rdata,
   input  logic [NSLV-1:0]    s_ack
);

   localparam int unsigned SELW = $clog2(NSLV);

   // Elaboration-time guard on the legal parameter ranges
   if (NSLV < 2 || NSLV > 16 || TIMEOUT < 1 || TIMEOUT > 65535 ||
       SEL_LSB + SELW > 32) begin : g_bad_param
      $error("sopc_bus_decoder: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE,
      ST_ERR
   } state_t;

   state_t            state;
   logic [SELW-1:0]   idx;
   logic [SELW-1:0]   dec_idx;
   logic              dec_ok;
   logic [NSLV-1:0]   dec_onehot;
   logic [31:0]       sel_rdata;
   logic              sel_ack;

`ifdef BUS_TIMEOUT_EN
   // Comparing against TIMEOUT-1 before incrementing makes s_ce stay high
   // for exactly TIMEOUT cycles.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   logic [15:0]       tmo_cnt;
`endif

   assign dec_idx = m_addr[SEL_LSB +: SELW];
   assign dec_ok  = (32'(dec_idx) < NSLV);

   // One-hot slave select for the incoming address
   always_comb begin
      dec_onehot = '0;
      for (int unsigned i = 0; i < NSLV; i++) begin
         if (dec_idx == SELW'(i)) begin
            dec_onehot[i] = 1'b1;
         end
      end
   end

   // Read data and ack of the registered (selected) slave only
   always_comb begin
      sel_rdata = '0;
      sel_ack   = 1'b0;
      for (int unsigned i = 0; i < NSLV; i++) begin
         if (idx == SELW'(i)) begin
            sel_rdata = s_rdata[32*i +: 32];
            sel_ack   = s_ack[i];
         end
      end
   end

   // Transaction FSM with registered slave-side and master-side outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         idx     <= '0;
         s_ce    <= '0;
         s_we    <= 1'b0;
         s_addr  <= '0;
         s_sel   <= '0;
         s_wdata <= '0;
         m_rdata <= '0;
         m_ack   <= 1'b0;
         m_err   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         tmo_cnt <= '0;
`endif
      end else begin
         m_ack <= 1'b0;
         m_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (m_ce) begin
                  s_we    <= m_we;
                  s_addr  <= m_addr;
                  s_sel   <= m_sel;
                  s_wdata <= m_wdata;
                  idx     <= dec_idx;
                  if (dec_ok) begin
                     s_ce  <= dec_onehot;
                     state <= ST_WAIT;
`ifdef BUS_TIMEOUT_EN
                     tmo_cnt <= '0;
`endif
                  end else begin
                     m_err   <= 1'b1;
                     m_rdata <= '0;
                     state   <= ST_ERR;
                  end
               end
            end
            ST_WAIT: begin
               if (sel_ack) begin
                  m_rdata <= sel_rdata;
                  s_ce    <= '0;
                  m_ack   <= 1'b1;
                  state   <= ST_DONE;
               end
`ifdef BUS_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  s_ce    <= '0;
                  m_err   <= 1'b1;
                  m_rdata <= '0;
                  state   <= ST_ERR;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
`endif
            end
            ST_DONE: state <= ST_IDLE;
            ST_ERR:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sopc_bus_decoder.sv
// Self-checking bench for sopc_bus_decoder: table vectors, randomized
// transactions against a transaction-level model, and hand-written sequences
// for decode error, timeout / no-timeout, and reset during WAIT.
module tb_sopc_bus_decoder;

   logic          clk = 1'b0;
   logic          rst;
   logic          m_ce, m_we;
   logic [31:0]   m_addr, m_wdata;
   logic [3:0]    m_sel;

   logic [31:0]   m_rdata;
   logic          m_ack, m_err;
   logic [3:0]    s_ce;
   logic          s_we;
   logic [31:0]   s_addr, s_wdata;
   logic [3:0]    s_sel;
   logic [127:0]  s_rdata;
   logic [3:0]    s_ack;

   logic [31:0]   m_rdata2;
   logic          m_ack2, m_err2;
   logic [2:0]    s_ce2;
   logic          s_we2;
   logic [31:0]   s_addr2, s_wdata2;
   logic [3:0]    s_sel2;
   logic [95:0]   s_rdata2;
   logic [2:0]    s_ack2;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdata;
      int unsigned waits;
      logic [31:0] rdata;
   } vec_t;

   always #5 clk = ~clk;

   sopc_bus_decoder #(.NSLV(4), .SEL_LSB(28), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel),
      .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
      .s_ce(s_ce), .s_we(s_we), .s_addr(s_addr), .s_sel(s_sel), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_ack(s_ack)
   );

   sopc_bus_decoder #(.NSLV(3), .SEL_LSB(28), .TIMEOUT(8)) dut3 (
      .clk(clk), .rst(rst),
      .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel),
      .m_rdata(m_rdata2), .m_ack(m_ack2), .m_err(m_err2),
      .s_ce(s_ce2), .s_we(s_we2), .s_addr(s_addr2), .s_sel(s_sel2), .s_wdata(s_wdata2),
      .s_rdata(s_rdata2), .s_ack(s_ack2)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; m_ce = 1'b0; s_ack = '0; s_ack2 = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Called at a negedge in an IDLE cycle. Model: slave index is
   // addr[29:28]; s_ce is one-hot for waits+1 cycles carrying the request
   // as issued, then one m_ack cycle returning the slave's data.
   task automatic do_txn(input vec_t v);
      logic [3:0]  exp_ce;
      int unsigned k;
      k      = int'(v.addr[29:28]);
      exp_ce = 4'b0001 << k;
      m_ce = 1'b1; m_we = v.we; m_addr = v.addr; m_sel = v.sel; m_wdata = v.wdata;
      @(negedge clk);
      for (int unsigned c = 0; c <= v.waits; c++) begin
         check("s_ce", 64'(s_ce), 64'(exp_ce));
         check("s_we", 64'(s_we), 64'(v.we));
         check("s_addr", 64'(s_addr), 64'(v.addr));
         check("s_sel", 64'(s_sel), 64'(v.sel));
         check("s_wdata", 64'(s_wdata), 64'(v.wdata));
         check("wait_m_ack", 64'(m_ack), 64'(0));
         check("wait_m_err", 64'(m_err), 64'(0));
         s_rdata = {$urandom, $urandom, $urandom, $urandom};
         // master inputs may wander once accepted; the registered copy is used
         m_addr = $urandom; m_we = 1'($urandom); m_sel = 4'($urandom); m_wdata = $urandom;
         if (c == v.waits) begin
            s_ack = exp_ce | 4'($urandom);
            s_rdata[k*32 +: 32] = v.rdata;
         end else begin
            s_ack = 4'($urandom) & ~exp_ce;
         end
         @(negedge clk);
      end
      check("done_m_ack", 64'(m_ack), 64'(1));
      check("done_m_err", 64'(m_err), 64'(0));
      check("done_s_ce", 64'(s_ce), 64'(0));
      check("done_m_rdata", 64'(m_rdata), 64'(v.rdata));
      s_ack = 4'($urandom);
      @(negedge clk);
      s_ack = '0;
      check("idle_m_ack", 64'(m_ack), 64'(0));
      check("idle_s_ce", 64'(s_ce), 64'(0));
      check("hold_m_rdata", 64'(m_rdata), 64'(v.rdata));
      m_ce = 1'b0;
   endtask

   initial begin
      vec_t vecs[4];
      vec_t v;

      vecs[0] = '{32'h2000_0010, 1'b0, 4'hF,    32'h0000_0000, 0, 32'hDEAD_BEEF};
      vecs[1] = '{32'h1000_0004, 1'b1, 4'b0011, 32'h0000_A5A5, 3, 32'h0000_0000};
      vecs[2] = '{32'h3000_0FFC, 1'b0, 4'b1000, 32'h0000_0000, 1, 32'h0BAD_F00D};
      vecs[3] = '{32'h0000_0000, 1'b1, 4'hF,    32'hFFFF_FFFF, 0, 32'h0000_0001};

      rst = 1'b0; m_ce = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_sel = '0;
      s_rdata = '0; s_ack = '0; s_rdata2 = '0; s_ack2 = '0;

      // reset state
      @(negedge clk);
      check("rst_s_ce", 64'(s_ce), 64'(0));
      check("rst_s_addr", 64'(s_addr), 64'(0));
      check("rst_s_wdata", 64'(s_wdata), 64'(0));
      check("rst_s_sel", 64'(s_sel), 64'(0));
      check("rst_s_we", 64'(s_we), 64'(0));
      check("rst_m_rdata", 64'(m_rdata), 64'(0));
      check("rst_m_ack", 64'(m_ack), 64'(0));
      check("rst_m_err", 64'(m_err), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // table vectors
      for (int i = 0; i < 4; i++) do_txn(vecs[i]);

      // randomized transactions
      for (int i = 0; i < 40; i++) begin
         v.addr  = $urandom;
         v.we    = 1'($urandom);
         v.sel   = 4'($urandom);
         v.wdata = $urandom;
         v.waits = $urandom_range(0, 5);
         v.rdata = $urandom;
         do_txn(v);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // NSLV=3: valid access to slave 1, then out-of-range index 3
      do_reset();
      m_ce = 1'b1; m_we = 1'b0; m_addr = 32'h1000_0000; m_sel = 4'hF; m_wdata = '0;
      @(negedge clk);
      check("n3_s_ce", 64'(s_ce2), 64'(3'b010));
      s_ack2 = 3'b010; s_rdata2[63:32] = 32'h1234_5678;
      @(negedge clk);
      s_ack2 = '0;
      check("n3_m_ack", 64'(m_ack2), 64'(1));
      check("n3_m_rdata", 64'(m_rdata2), 64'(32'h1234_5678));
      m_ce = 1'b0;
      @(negedge clk);
      m_ce = 1'b1; m_addr = 32'h3000_0000;
      @(negedge clk);
      check("n3_err_s_ce", 64'(s_ce2), 64'(0));
      check("n3_m_err", 64'(m_err2), 64'(1));
      check("n3_err_no_ack", 64'(m_ack2), 64'(0));
      check("n3_err_rdata", 64'(m_rdata2), 64'(0));
      @(negedge clk);
      check("n3_err_pulse", 64'(m_err2), 64'(0));
      m_ce = 1'b0;

      do_reset();
      @(negedge clk);
      do_txn(vecs[0]);

      // slave 0 never acks
      m_ce = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0100; m_sel = 4'hF;
      @(negedge clk);
`ifdef BUS_TIMEOUT_EN
      for (int c = 0; c < 8; c++) begin
         check("tmo_s_ce", 64'(s_ce), 64'(4'b0001));
         check("tmo_no_err", 64'(m_err), 64'(0));
         @(negedge clk);
      end
      check("tmo_m_err", 64'(m_err), 64'(1));
      check("tmo_s_ce_drop", 64'(s_ce), 64'(0));
      check("tmo_no_ack", 64'(m_ack), 64'(0));
      check("tmo_m_rdata", 64'(m_rdata), 64'(0));
      @(negedge clk);
      check("tmo_err_pulse", 64'(m_err), 64'(0));
      m_ce = 1'b0;
      // ack in the final allowed cycle wins over the timeout
      v = '{32'h0000_0200, 1'b0, 4'hF, 32'h0, 7, 32'hCAFE_0001};
      do_txn(v);
`else
      for (int c = 0; c < 120; c++) begin
         check("hang_s_ce", 64'(s_ce), 64'(4'b0001));
         check("hang_no_err", 64'(m_err), 64'(0));
         @(negedge clk);
      end
      m_ce = 1'b0;
      do_reset();
      @(negedge clk);
`endif

      // reset in the middle of WAIT with a stray ack from slave 3
      do_txn(vecs[0]);
      m_ce = 1'b1; m_we = 1'b1; m_addr = 32'h1000_0040; m_sel = 4'b0110; m_wdata = 32'h5A5A_0001;
      @(negedge clk);
      check("mid_s_ce", 64'(s_ce), 64'(4'b0010));
      s_ack = 4'b1000;
      @(negedge clk);
      check("stray_s_ce", 64'(s_ce), 64'(4'b0010));
      check("stray_no_ack", 64'(m_ack), 64'(0));
      #2 rst = 1'b0;
      #1;
      check("arst_s_ce", 64'(s_ce), 64'(0));
      check("arst_s_we", 64'(s_we), 64'(0));
      check("arst_s_addr", 64'(s_addr), 64'(0));
      check("arst_s_sel", 64'(s_sel), 64'(0));
      check("arst_s_wdata", 64'(s_wdata), 64'(0));
      check("arst_m_rdata", 64'(m_rdata), 64'(0));
      check("arst_m_ack", 64'(m_ack), 64'(0));
      check("arst_m_err", 64'(m_err), 64'(0));
      s_ack = '0; m_ce = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_ack", 64'(m_ack), 64'(0));
      check("post_rst_err", 64'(m_err), 64'(0));
      check("post_rst_s_ce", 64'(s_ce), 64'(0));
      do_txn(vecs[1]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // m_ack and m_err are mutually exclusive on both instances
   always @(negedge clk) begin
      if (rst && ((m_ack && m_err) || (m_ack2 && m_err2))) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ack_err_excl: ack/err both high at %0t", $time);
      end
   end

endmodule

// File: doc/sopc_bus_decoder.md
SOPC_BUS_DECODER -- requirements
Module: sopc_bus_decoder

Interface
REQ-001 SHALL have parameter NSLV, default 4, meaning number of slave ports (2..16); SELW = ceil(log2(NSLV)).
REQ-002 SHALL have parameter SEL_LSB, default 28, meaning lowest address bit of the slave-index field addr[SEL_LSB +: SELW].
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning cycles allowed between request accept and slave ack (1..65535).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports m_ce/m_we  input  1/1  master request valid / write.
REQ-007 SHALL have ports m_addr/m_wdata  input  32/32  master address / write data.
REQ-008 SHALL have port m_sel  input  4  byte enables.
REQ-009 SHALL have ports m_rdata  output  32, m_ack  output  1, m_err  output  1  read data, completion pulse, error pulse.
REQ-010 SHALL have ports s_ce  output  NSLV, s_we  output  1, s_addr  output  32, s_sel  output  4, s_wdata  output  32  one-hot select plus broadcast request.
REQ-011 SHALL have ports s_rdata  input  NSLV*32 (slave i at [32i+31:32i]), s_ack  input  NSLV.

Function
REQ-012 SHALL implement FSM IDLE, WAIT, DONE, ERR.
REQ-013 IDLE: on m_ce=1 SHALL register m_we/m_addr/m_sel/m_wdata and decoded index idx, then go WAIT if idx<NSLV, else ERR.
REQ-014 WAIT: SHALL drive s_ce[idx]=1, all other s_ce bits 0, and s_we/s_addr/s_sel/s_wdata from the registered copy.
REQ-015 WAIT: on s_ack[idx]=1 SHALL capture s_rdata slice idx into m_rdata and go DONE; the slave may ack in its first s_ce cycle.
REQ-016 DONE: SHALL assert m_ack=1 for exactly one cycle, s_ce=0, then return to IDLE.
REQ-017 ERR: SHALL assert m_err=1 for exactly one cycle, s_ce=0, m_rdata=0, then return to IDLE.
REQ-018 Latency: a zero-wait slave SHALL give m_ce sampled at edge N, s_ce high in cycle N+1, and m_ack high in cycle N+2; each slave wait cycle adds one.
REQ-019 m_ce SHALL be ignored in WAIT, DONE and ERR; the master holds the request until m_ack or m_err, and a new request is accepted no earlier than the cycle after the pulse.
REQ-020 s_ack bits of unselected slaves, and any s_ack in IDLE/DONE/ERR, SHALL be ignored.
REQ-021 m_rdata SHALL hold its last captured value until the next capture or error; write transactions SHALL also capture (slave data don't-care).
REQ-022 m_ack and m_err SHALL never be high together.

Reset
REQ-023 rst=0 SHALL asynchronously force IDLE, s_ce=0, s_we=0, s_addr=0, s_sel=0, s_wdata=0, m_rdata=0, m_ack=0, m_err=0, timeout counter=0.
REQ-024 Reset during WAIT SHALL abandon the transaction with no m_ack/m_err; the first request after release SHALL be accepted normally.

Configuration
REQ-025 With BUS_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entering WAIT and increment each WAIT cycle without ack; on reaching TIMEOUT it SHALL drop s_ce and go ERR.
REQ-026 If ack and timeout coincide in the same cycle, ack SHALL win (go DONE).
REQ-027 Without BUS_TIMEOUT_EN there SHALL be no counter, and WAIT SHALL persist indefinitely until ack or reset.

Verification
REQ-028 NSLV=4, read 0x2000_0010, slave 2 acks in first s_ce cycle with 0xDEADBEEF -> s_ce=4'b0100 for 1 cycle; m_ack in cycle N+2 with m_rdata=0xDEADBEEF.
REQ-029 Write 0x1000_0004, m_sel=4'b0011, data 0x0000_A5A5, slave 1 acks after 3 wait cycles -> s_ce=4'b0010 for 4 cycles with s_we=1, s_sel=0011; one m_ack pulse.
REQ-030 NSLV=3, access 0x3000_0000 -> no s_ce asserted; m_err pulse in cycle N+1; m_rdata=0.
REQ-031 BUS_TIMEOUT_EN, TIMEOUT=8, slave 0 never acks -> s_ce[0] high 8 cycles, then m_err pulse; without macro, s_ce[0] stays high for 100+ cycles.
REQ-032 Slave 3 acks stray while slave 1 is selected; rst pulled low mid-WAIT -> stray ack ignored; outputs zero immediately on rst; next request completes normally.
